// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard that issues operand pairs to an ALU stage.
// Optional macro REGFILE_WB_BYPASS_EN forwards a same-cycle writeback into an accepted read.
module regfile_scoreboard #(
   parameter int NB_WORD     = 32,
   parameter int NB_REG_ADDR = 5
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_rd_valid,
   output logic                        o_rd_ready,
   input  logic [NB_REG_ADDR-1:0]      i_rs1_addr,
   input  logic [NB_REG_ADDR-1:0]      i_rs2_addr,
   input  logic [NB_REG_ADDR-1:0]      i_rd_addr,
   input  logic                        i_rd_reserve,
   output logic                        o_op_valid,
   input  logic                        i_op_ready,
   output logic [NB_WORD-1:0]          o_rs1,
   output logic [NB_WORD-1:0]          o_rs2,
   input  logic                        i_wb_valid,
   input  logic [NB_REG_ADDR-1:0]      i_wb_addr,
   input  logic [NB_WORD-1:0]          i_wb_data,
   output logic [2**NB_REG_ADDR-1:0]   o_busy
);

   localparam int NREG = 2**NB_REG_ADDR;

   logic [NB_WORD-1:0] regs [NREG];
   logic [NREG-1:0]    busy;
   logic [NREG-1:0]    wb_mask;
   logic [NREG-1:0]    set_mask;
   logic [NREG-1:0]    busy_view;
   logic               wb_en;
   logic               hazard;
   logic               accept;
   logic [NB_WORD-1:0] rs1_val;
   logic [NB_WORD-1:0] rs2_val;

   // Register 0 is hardwired: writebacks to it never touch data or busy state.
   assign wb_en = i_wb_valid && (i_wb_addr != '0);

   always_comb begin
      wb_mask = '0;
      if (wb_en) wb_mask[i_wb_addr] = 1'b1;
   end

`ifdef REGFILE_WB_BYPASS_EN
   assign busy_view = busy & ~wb_mask;

   always_comb begin
      rs1_val = regs[i_rs1_addr];
      rs2_val = regs[i_rs2_addr];
      if (wb_en && (i_wb_addr == i_rs1_addr)) rs1_val = i_wb_data;
      if (wb_en && (i_wb_addr == i_rs2_addr)) rs2_val = i_wb_data;
   end
`else
   assign busy_view = busy;

   always_comb begin
      rs1_val = regs[i_rs1_addr];
      rs2_val = regs[i_rs2_addr];
   end
`endif

   assign hazard     = busy_view[i_rs1_addr] | busy_view[i_rs2_addr]
                     | (i_rd_reserve & busy_view[i_rd_addr]);
   assign o_rd_ready = (!o_op_valid | i_op_ready) & !hazard;
   assign accept     = i_rd_valid & o_rd_ready;

   always_comb begin
      set_mask = '0;
      if (accept && i_rd_reserve && (i_rd_addr != '0)) set_mask[i_rd_addr] = 1'b1;
   end

   // A reservation and a writeback on the same index resolve with the reservation winning.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) busy <= '0;
      else          busy <= (busy & ~wb_mask) | set_mask;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wb_en) begin
         regs[i_wb_addr] <= i_wb_data;
      end
   end

   // Operand pair is held while the ALU stage stalls; accept is impossible in that state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_op_valid <= 1'b0;
         o_rs1      <= '0;
         o_rs2      <= '0;
      end else if (accept) begin
         o_op_valid <= 1'b1;
         o_rs1      <= rs1_val;
         o_rs2      <= rs2_val;
      end else if (i_op_ready) begin
         o_op_valid <= 1'b0;
      end
   end

   assign o_busy = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: operand pairs are predicted into exp_q when a request is driven
// and popped when the DUT presents them. Honours REGFILE_WB_BYPASS_EN for the hazard scenario.
module tb_regfile_scoreboard;

   localparam int NB_WORD     = 32;
   localparam int NB_REG_ADDR = 5;
   localparam int NREG        = 32;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_rd_valid;
   logic              o_rd_ready;
   logic [4:0]        i_rs1_addr;
   logic [4:0]        i_rs2_addr;
   logic [4:0]        i_rd_addr;
   logic              i_rd_reserve;
   logic              o_op_valid;
   logic              i_op_ready;
   logic [31:0]       o_rs1;
   logic [31:0]       o_rs2;
   logic              i_wb_valid;
   logic [4:0]        i_wb_addr;
   logic [31:0]       i_wb_data;
   logic [NREG-1:0]   o_busy;

   logic [63:0] exp_q[$];
   logic [63:0] exp_pair;
   logic [31:0] model_regs [NREG];
   int          checks;
   int          failures;

   regfile_scoreboard #(.NB_WORD(NB_WORD), .NB_REG_ADDR(NB_REG_ADDR)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .i_rd_addr(i_rd_addr), .i_rd_reserve(i_rd_reserve),
      .o_op_valid(o_op_valid), .i_op_ready(i_op_ready),
      .o_rs1(o_rs1), .o_rs2(o_rs2),
      .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_busy(o_busy)
   );

   // clock / watchdog
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_idle();
      i_rd_valid   = 1'b0;
      i_rs1_addr   = 5'd0;
      i_rs2_addr   = 5'd0;
      i_rd_addr    = 5'd0;
      i_rd_reserve = 1'b0;
      i_wb_valid   = 1'b0;
      i_wb_addr    = 5'd0;
      i_wb_data    = 32'h0;
   endtask

   task automatic drive_req(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic reserve);
      i_rd_valid   = 1'b1;
      i_rs1_addr   = rs1;
      i_rs2_addr   = rs2;
      i_rd_addr    = rd;
      i_rd_reserve = reserve;
   endtask

   task automatic drive_wb(input logic [4:0] addr, input logic [31:0] data);
      i_wb_valid = 1'b1;
      i_wb_addr  = addr;
      i_wb_data  = data;
      if (addr != 5'd0) model_regs[addr] = data;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      drive_idle();
      i_op_ready = 1'b1;
      for (int i = 0; i < NREG; i++) model_regs[i] = 32'h0;
      #1;
      checks++;
      if ({o_op_valid, o_busy} !== 33'h0)
         $display("FAIL reset_ctl: got op_valid=%b busy=%h want 0/0", o_op_valid, o_busy);
      checks++;
      if ({o_rs1, o_rs2} !== 64'h0)
         $display("FAIL reset_ops: got %h/%h want 0/0", o_rs1, o_rs2);
      step();
      step();
      checks++;
      if ({o_op_valid, o_busy, o_rs1, o_rs2} !== 97'h0)
         $display("FAIL reset_clocked: got op_valid=%b busy=%h want all zero", o_op_valid, o_busy);
      if ({o_op_valid, o_busy, o_rs1, o_rs2} !== 97'h0) failures++;
      if ({o_op_valid, o_busy} !== 33'h0) failures++;
      if ({o_rs1, o_rs2} !== 64'h0) failures++;
      i_rst_n = 1'b1;
      step();
   endtask

   task automatic test_read_write();
      drive_wb(5'd5, 32'h0000_00AA);
      step();
      i_wb_valid = 1'b0;
      drive_req(5'd5, 5'd0, 5'd0, 1'b0);
      #1;
      checks++;
      if (o_rd_ready !== 1'b1) begin
         failures++;
         $display("FAIL rw_ready: got %b want 1", o_rd_ready);
      end
      exp_q.push_back({32'h0000_00AA, 32'h0});
      step();
      drive_idle();
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2} !== {1'b1, exp_pair}) begin
         failures++;
         $display("FAIL rw_pair: got v=%b %h/%h want v=1 %h", o_op_valid, o_rs1, o_rs2, exp_pair);
      end
      step();
      checks++;
      if (o_op_valid !== 1'b0) begin
         failures++;
         $display("FAIL rw_drain: got op_valid=%b want 0", o_op_valid);
      end
   endtask

   task automatic test_hazard();
      drive_req(5'd5, 5'd0, 5'd7, 1'b1);
      exp_q.push_back({32'h0000_00AA, 32'h0});
      step();
      drive_req(5'd7, 5'd0, 5'd0, 1'b0);
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2, o_busy} !== {1'b1, exp_pair, 32'h0000_0080}) begin
         failures++;
         $display("FAIL hz_reserve: got v=%b %h/%h busy=%h want v=1 %h busy=00000080",
                  o_op_valid, o_rs1, o_rs2, o_busy, exp_pair);
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (o_rd_ready !== 1'b0) begin
            failures++;
            $display("FAIL hz_stall%0d: got ready=%b want 0", c, o_rd_ready);
         end
         step();
      end
      drive_wb(5'd7, 32'h0000_1234);
      #1;
`ifdef REGFILE_WB_BYPASS_EN
      checks++;
      if (o_rd_ready !== 1'b1) begin
         failures++;
         $display("FAIL hz_wb_cycle: got ready=%b want 1 (bypass)", o_rd_ready);
      end
      exp_q.push_back({32'h0000_1234, 32'h0});
      step();
      drive_idle();
`else
      checks++;
      if (o_rd_ready !== 1'b0) begin
         failures++;
         $display("FAIL hz_wb_cycle: got ready=%b want 0 (no bypass)", o_rd_ready);
      end
      step();
      i_wb_valid = 1'b0;
      #1;
      checks++;
      if (o_rd_ready !== 1'b1) begin
         failures++;
         $display("FAIL hz_after_wb: got ready=%b want 1", o_rd_ready);
      end
      exp_q.push_back({32'h0000_1234, 32'h0});
      step();
      drive_idle();
`endif
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2, o_busy} !== {1'b1, exp_pair, 32'h0}) begin
         failures++;
         $display("FAIL hz_pair: got v=%b %h/%h busy=%h want v=1 %h busy=0",
                  o_op_valid, o_rs1, o_rs2, o_busy, exp_pair);
      end
   endtask

   task automatic test_hold();
      drive_wb(5'd4, 32'h0000_0055);
      step();
      i_wb_valid = 1'b0;
      i_op_ready = 1'b0;
      drive_req(5'd4, 5'd5, 5'd0, 1'b0);
      exp_q.push_back({32'h0000_0055, 32'h0000_00AA});
      step();
      drive_req(5'd0, 5'd0, 5'd0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         if (c == 0) drive_wb(5'd4, 32'h0000_0099);
         else i_wb_valid = 1'b0;
         #1;
         checks++;
         if ({o_rd_ready, o_op_valid} !== 2'b01) begin
            failures++;
            $display("FAIL hold_ctl%0d: got ready=%b valid=%b want 0/1", c, o_rd_ready, o_op_valid);
         end
         checks++;
         if ({o_rs1, o_rs2} !== {32'h0000_0055, 32'h0000_00AA}) begin
            failures++;
            $display("FAIL hold_ops%0d: got %h/%h want 00000055/000000aa", c, o_rs1, o_rs2);
         end
         step();
      end
      i_wb_valid = 1'b0;
      i_op_ready = 1'b1;
      #1;
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_rd_ready, o_op_valid, o_rs1, o_rs2} !== {2'b11, exp_pair}) begin
         failures++;
         $display("FAIL hold_release: got ready=%b v=%b %h/%h want 1/1 %h",
                  o_rd_ready, o_op_valid, o_rs1, o_rs2, exp_pair);
      end
      exp_q.push_back({32'h0, 32'h0});
      step();
      drive_idle();
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2} !== {1'b1, exp_pair}) begin
         failures++;
         $display("FAIL hold_next: got v=%b %h/%h want v=1 %h", o_op_valid, o_rs1, o_rs2, exp_pair);
      end
   endtask

   task automatic test_same_cycle();
      drive_req(5'd0, 5'd0, 5'd3, 1'b1);
      drive_wb(5'd3, 32'h0000_0077);
      exp_q.push_back({32'h0, 32'h0});
      step();
      drive_idle();
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2, o_busy} !== {1'b1, exp_pair, 32'h0000_0008}) begin
         failures++;
         $display("FAIL same_set_wins: got v=%b %h/%h busy=%h want v=1 %h busy=00000008",
                  o_op_valid, o_rs1, o_rs2, o_busy, exp_pair);
      end
      drive_wb(5'd0, 32'hFFFF_FFFF);
      step();
      drive_wb(5'd3, 32'h0000_0033);
      step();
      drive_wb(5'd6, 32'h0000_0066);
      step();
      i_wb_valid = 1'b0;
      checks++;
      if (o_busy !== 32'h0) begin
         failures++;
         $display("FAIL same_busy_clear: got busy=%h want 0", o_busy);
      end
      drive_req(5'd0, 5'd6, 5'd0, 1'b0);
      exp_q.push_back({32'h0, 32'h0000_0066});
      step();
      drive_req(5'd3, 5'd0, 5'd0, 1'b0);
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2} !== {1'b1, exp_pair}) begin
         failures++;
         $display("FAIL same_x0_read: got v=%b %h/%h want v=1 %h", o_op_valid, o_rs1, o_rs2, exp_pair);
      end
      exp_q.push_back({32'h0000_0033, 32'h0});
      step();
      drive_idle();
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2} !== {1'b1, exp_pair}) begin
         failures++;
         $display("FAIL same_x3_read: got v=%b %h/%h want v=1 %h", o_op_valid, o_rs1, o_rs2, exp_pair);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] pool [6];
      logic [4:0] a;
      logic [4:0] b;
      pool[0] = 5'd0;  pool[1] = 5'd4;  pool[2] = 5'd10;
      pool[3] = 5'd11; pool[4] = 5'd12; pool[5] = 5'd13;
      for (int r = 10; r < 14; r++) begin
         drive_wb(5'(r), $urandom);
         step();
      end
      i_wb_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin
         a = pool[$urandom_range(0, 5)];
         b = pool[$urandom_range(0, 5)];
         drive_req(a, b, 5'd0, 1'b0);
         #1;
         checks++;
         if (o_rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready%0d: got %b want 1", n, o_rd_ready);
         end
         exp_q.push_back({model_regs[a], model_regs[b]});
         step();
         checks++;
         exp_pair = exp_q.pop_front();
         if ({o_op_valid, o_rs1, o_rs2} !== {1'b1, exp_pair}) begin
            failures++;
            $display("FAIL b2b_pair%0d: got v=%b %h/%h want v=1 %h", n, o_op_valid, o_rs1, o_rs2, exp_pair);
         end
      end
      drive_idle();
      step();
      checks++;
      if (o_op_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain: got op_valid=%b want 0", o_op_valid);
      end
   endtask

   task automatic test_reset_mid();
      i_op_ready = 1'b0;
      drive_req(5'd5, 5'd4, 5'd9, 1'b1);
      step();
      drive_idle();
      checks++;
      if ({o_op_valid, o_busy} !== {1'b1, 32'h0000_0200}) begin
         failures++;
         $display("FAIL mid_setup: got v=%b busy=%h want 1/00000200", o_op_valid, o_busy);
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_op_valid, o_busy, o_rs1, o_rs2} !== 97'h0) begin
         failures++;
         $display("FAIL mid_async: got v=%b busy=%h ops=%h/%h want all zero",
                  o_op_valid, o_busy, o_rs1, o_rs2);
      end
      exp_q.delete();
      for (int i = 0; i < NREG; i++) model_regs[i] = 32'h0;
      #1;
      i_rst_n    = 1'b1;
      i_op_ready = 1'b1;
      step();
      drive_req(5'd5, 5'd9, 5'd9, 1'b1);
      #1;
      checks++;
      if (o_rd_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_ready: got %b want 1", o_rd_ready);
      end
      exp_q.push_back({model_regs[5], model_regs[9]});
      step();
      drive_idle();
      checks++;
      exp_pair = exp_q.pop_front();
      if ({o_op_valid, o_rs1, o_rs2, o_busy} !== {1'b1, exp_pair, 32'h0000_0200}) begin
         failures++;
         $display("FAIL mid_after: got v=%b %h/%h busy=%h want v=1 %h busy=00000200",
                  o_op_valid, o_rs1, o_rs2, o_busy, exp_pair);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_read_write();
      test_hazard();
      test_hold();
      test_same_cycle();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter NB_WORD, default 32, data word width in bits.
REQ-002 SHALL have parameter NB_REG_ADDR, default 5, register index width; the register count is 2**NB_REG_ADDR.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rd_valid  input  1  operand-read request valid.
REQ-006 SHALL have port o_rd_ready  output  1  operand-read request accepted this cycle.
REQ-007 SHALL have port i_rs1_addr  input  NB_REG_ADDR  source register 1 index.
REQ-008 SHALL have port i_rs2_addr  input  NB_REG_ADDR  source register 2 index.
REQ-009 SHALL have port i_rd_addr  input  NB_REG_ADDR  destination register to reserve.
REQ-010 SHALL have port i_rd_reserve  input  1  the request writes a destination register.
REQ-011 SHALL have port o_op_valid  output  1  operand pair valid toward the ALU stage.
REQ-012 SHALL have port i_op_ready  input  1  the ALU stage accepts the operand pair.
REQ-013 SHALL have port o_rs1  output  NB_WORD  operand 1 value.
REQ-014 SHALL have port o_rs2  output  NB_WORD  operand 2 value.
REQ-015 SHALL have port i_wb_valid  input  1  writeback strobe.
REQ-016 SHALL have port i_wb_addr  input  NB_REG_ADDR  writeback register index.
REQ-017 SHALL have port i_wb_data  input  NB_WORD  writeback data (ALU result).
REQ-018 SHALL have port o_busy  output  2**NB_REG_ADDR  scoreboard busy bits, one per register.

Function
REQ-019 A request SHALL be accepted on a cycle where i_rd_valid and o_rd_ready are both 1.
REQ-020 o_rd_ready SHALL be combinational: (!o_op_valid | i_op_ready) & !hazard.
REQ-021 The hazard term SHALL be 1 when busy[rs1], busy[rs2], or (i_rd_reserve & busy[rd]) is set; index 0 is never busy.
REQ-022 On acceptance, o_rs1 and o_rs2 SHALL be registered and o_op_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-023 Reads of register 0 SHALL return 0.
REQ-024 While o_op_valid=1 and i_op_ready=0, o_rs1, o_rs2 and o_op_valid SHALL hold stable, including across writebacks to the source registers.
REQ-025 o_op_valid SHALL clear after an i_op_ready handshake when no new request is accepted in the same cycle.
REQ-026 On acceptance with i_rd_reserve=1 and i_rd_addr!=0, busy[i_rd_addr] SHALL be set on the next edge.
REQ-027 When i_wb_valid=1 and i_wb_addr!=0, the register SHALL be written and busy[i_wb_addr] cleared on the next edge; a writeback to register 0 SHALL be ignored.
REQ-028 A writeback to a non-busy register SHALL update the data and leave busy at 0.
REQ-029 If a reservation set and a writeback clear target the same index in one cycle, set SHALL win.

Reset
REQ-030 While i_rst_n=0, all registers, o_busy, o_op_valid, o_rs1 and o_rs2 SHALL be 0, independent of i_clk.
REQ-031 Reset asserted mid-handshake SHALL drop o_op_valid immediately and discard all reservations.

Configuration
REQ-032 With macro REGFILE_WB_BYPASS_EN defined, a same-cycle writeback SHALL clear the hazard for the written index, and its i_wb_data SHALL be forwarded to an accepted read of that index.
REQ-033 Without REGFILE_WB_BYPASS_EN, a read SHALL see the pre-writeback value, and a busy source SHALL stall until the cycle after its writeback.

Verification
REQ-034 Reset, write x5=0x0000_00AA, then read rs1=5, rs2=0 -> next cycle o_op_valid=1, o_rs1=0x0000_00AA, o_rs2=0.
REQ-035 Accept with rd=7 reserve, then read rs1=7 -> o_rd_ready=0 until x7 writeback of 0x1234; bypass on: accepted in the writeback cycle, o_rs1=0x1234; bypass off: accepted one cycle later.
REQ-036 o_op_valid=1, i_op_ready=0 for 3 cycles, with a writeback to the source register -> o_rs1 unchanged, o_rd_ready=0 throughout.
REQ-037 Reserve x3 and write back x3 in the same cycle -> busy[3]=1 afterwards; writeback to x0 of 0xFFFF_FFFF -> x0 still reads 0.
REQ-038 Assert i_rst_n=0 asynchronously with o_op_valid=1 and busy[9]=1 -> o_op_valid=0 and o_busy=0 before the next clock edge.
